// File: rtl/composite_timing_gen.sv
// NTSC-style 240p composite timing: counts (h,v) on the video clock and registers
// the sync/burst/active decode plus pixel coordinates for the modulator and pixel pipe.
`timescale 1ns/1ps
module composite_timing_gen #(
   parameter int H_TOTAL        = 1588,
   parameter int HSYNC_W        = 117,
   parameter int BURST_START    = 132,
   parameter int BURST_W        = 63,
   parameter int ACTIVE_START   = 250,
   parameter int ACTIVE_W       = 1280,
   parameter int V_TOTAL        = 262,
   parameter int V_ACTIVE_START = 21,
   parameter int V_ACTIVE_H     = 240
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       sync_n,
   output logic       active,
   output logic       color_burst,
   output logic       line_start,
   output logic       frame_start,
   output logic [9:0] pixel_x,
   output logic [7:0] pixel_y
);

   localparam int HW   = $clog2(H_TOTAL + 1);
   localparam int VW   = $clog2(V_TOTAL + 1);
   localparam int HALF = H_TOTAL / 2;
   localparam int EQ_W = HSYNC_W / 2;

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_HSYNC   = HW'(HSYNC_W);
   localparam logic [HW-1:0] H_EQ_W    = HW'(EQ_W);
   localparam logic [HW-1:0] H_HALF    = HW'(HALF);
   localparam logic [HW-1:0] H_EQ2_END = HW'(HALF + EQ_W);
   localparam logic [HW-1:0] H_VS1_END = HW'(HALF - HSYNC_W);
   localparam logic [HW-1:0] H_VS2_END = HW'(H_TOTAL - HSYNC_W);
   localparam logic [HW-1:0] H_BURST_S = HW'(BURST_START);
   localparam logic [HW-1:0] H_BURST_E = HW'(BURST_START + BURST_W);
   localparam logic [HW-1:0] H_ACT_S   = HW'(ACTIVE_START);
   localparam logic [HW-1:0] H_ACT_E   = HW'(ACTIVE_START + ACTIVE_W);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_S   = VW'(V_ACTIVE_START);
   localparam logic [VW-1:0] V_ACT_E   = VW'(V_ACTIVE_START + V_ACTIVE_H);

   if (BURST_START < HSYNC_W || BURST_START + BURST_W > ACTIVE_START ||
       ACTIVE_START + ACTIVE_W > H_TOTAL || V_ACTIVE_START + V_ACTIVE_H > V_TOTAL) begin : g_bad_params
      $error("composite_timing_gen: illegal timing parameters");
   end

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          sync_n_q, sync_n_d;
   logic          active_q, active_d;
   logic          color_burst_q, color_burst_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic [9:0]    pixel_x_q, pixel_x_d;
   logic [7:0]    pixel_y_q, pixel_y_d;

   logic          eq_line, vs_line, sync_low;
   logic [10:0]   h_off;
   logic [8:0]    v_off;
   logic          unused_bits;

   assign unused_bits = ^{h_off[0], v_off[8]};

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end

      // Lines 0-2 and 6-8 carry equalizing pulses; 3-5 carry serrated broad pulses.
      eq_line = (v_cnt_q <= VW'(2)) || (v_cnt_q >= VW'(6) && v_cnt_q <= VW'(8));
      vs_line = (v_cnt_q >= VW'(3)) && (v_cnt_q <= VW'(5));

      if (eq_line)
         sync_low = (h_cnt_q < H_EQ_W) || (h_cnt_q >= H_HALF && h_cnt_q < H_EQ2_END);
      else if (vs_line)
         sync_low = (h_cnt_q < H_VS1_END) || (h_cnt_q >= H_HALF && h_cnt_q < H_VS2_END);
      else
         sync_low = (h_cnt_q < H_HSYNC);

      sync_n_d      = ~sync_low;
      color_burst_d = !eq_line && !vs_line && h_cnt_q >= H_BURST_S && h_cnt_q < H_BURST_E;
      active_d      = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E) &&
                      (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

      // Offsets wrap outside the window; only the in-window result is kept.
      h_off     = 11'(h_cnt_q) - 11'(ACTIVE_START);
      v_off     = 9'(v_cnt_q) - 9'(V_ACTIVE_START);
      pixel_x_d = active_d ? h_off[10:1] : '0;
      pixel_y_d = active_d ? v_off[7:0] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         sync_n_q      <= 1'b1;
         active_q      <= 1'b0;
         color_burst_q <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         sync_n_q      <= sync_n_d;
         active_q      <= active_d;
         color_burst_q <= color_burst_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
      end
   end

   assign sync_n      = sync_n_q;
   assign active      = active_q;
   assign color_burst = color_burst_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;

endmodule

// File: tb/tb_composite_timing_gen.sv
// Bench for composite_timing_gen: a full-size instance and a shrunken-timing instance,
// each compared every clock against a position-based reference model through a queue.
`timescale 1ns/1ps
module tb_composite_timing_gen;

   // Full-size timing (instance A)
   localparam int A_HT = 1588, A_HS = 117, A_BS = 132, A_BW = 63, A_AS = 250, A_AW = 1280;
   localparam int A_VT = 262, A_VAS = 21, A_VAH = 240;
   // Shrunken timing (instance B), small enough to run whole frames
   localparam int B_HT = 200, B_HS = 16, B_BS = 20, B_BW = 10, B_AS = 40, B_AW = 140;
   localparam int B_VT = 30, B_VAS = 10, B_VAH = 16;

   localparam logic [22:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a_n = 1'b0, rst_b_n = 1'b0;
   logic       a_sync_n, a_active, a_burst, a_ls, a_fs;
   logic [9:0] a_px;
   logic [7:0] a_py;
   logic       b_sync_n, b_active, b_burst, b_ls, b_fs;
   logic [9:0] b_px;
   logic [7:0] b_py;

   composite_timing_gen u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .sync_n(a_sync_n), .active(a_active), .color_burst(a_burst),
      .line_start(a_ls), .frame_start(a_fs), .pixel_x(a_px), .pixel_y(a_py));

   composite_timing_gen #(
      .H_TOTAL(B_HT), .HSYNC_W(B_HS), .BURST_START(B_BS), .BURST_W(B_BW),
      .ACTIVE_START(B_AS), .ACTIVE_W(B_AW), .V_TOTAL(B_VT),
      .V_ACTIVE_START(B_VAS), .V_ACTIVE_H(B_VAH)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .sync_n(b_sync_n), .active(b_active), .color_burst(b_burst),
      .line_start(b_ls), .frame_start(b_fs), .pixel_x(b_px), .pixel_y(b_py));

   int checks = 0;
   int errors = 0;
   int printed = 0;
   logic [22:0] q_a[$];
   logic [22:0] q_b[$];
   int edges_a = 0;
   int edges_b = 0;

   // Expected outputs for position (h,v), straight from the line-type rules.
   function automatic logic [22:0] decode(input int h, input int v, input int ht, input int hs,
                                          input int bs, input int bw, input int as_, input int aw,
                                          input int vas, input int vah);
      int  half, eqw, px, py;
      bit  eql, vsl, low, act, cb;
      half = ht / 2;
      eqw  = hs / 2;
      eql  = (v <= 2) || (v >= 6 && v <= 8);
      vsl  = (v >= 3 && v <= 5);
      if (eql)      low = (h < eqw) || (h >= half && h < half + eqw);
      else if (vsl) low = (h < half - hs) || (h >= half && h < ht - hs);
      else          low = (h < hs);
      cb  = !eql && !vsl && h >= bs && h < bs + bw;
      act = (h >= as_ && h < as_ + aw && v >= vas && v < vas + vah);
      px  = act ? (h - as_) / 2 : 0;
      py  = act ? v - vas : 0;
      return {~low, act, cb, (h == 0), (h == 0 && v == 0), 10'(px), 8'(py)};
   endfunction

   task automatic compare(input string name, input logic [22:0] got, input logic [22:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (printed < 40) begin
            printed++;
            $display("FAIL %s t=%0t got {sn,act,cb,ls,fs}=%b px=%0d py=%0d required {sn,act,cb,ls,fs}=%b px=%0d py=%0d",
                     name, $time, got[22:18], got[17:8], got[7:0], exp[22:18], exp[17:8], exp[7:0]);
         end
      end
   endtask

   // Reference models: each clock edge advances one position from reset release.
   initial forever begin
      @(posedge clk);
      if (!rst_a_n) begin
         edges_a = 0;
         q_a.push_back(RST_VEC);
      end else begin
         q_a.push_back(decode(edges_a % A_HT, (edges_a / A_HT) % A_VT,
                              A_HT, A_HS, A_BS, A_BW, A_AS, A_AW, A_VAS, A_VAH));
         edges_a++;
      end
   end

   initial forever begin
      @(posedge clk);
      if (!rst_b_n) begin
         edges_b = 0;
         q_b.push_back(RST_VEC);
      end else begin
         q_b.push_back(decode(edges_b % B_HT, (edges_b / B_HT) % B_VT,
                              B_HT, B_HS, B_BS, B_BW, B_AS, B_AW, B_VAS, B_VAH));
         edges_b++;
      end
   end

   // Monitors: outputs are presented every clock; sample 1 ns after the edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0)
         compare("a_outputs", {a_sync_n, a_active, a_burst, a_ls, a_fs, a_px, a_py}, q_a.pop_front());
      if (q_b.size() > 0)
         compare("b_outputs", {b_sync_n, b_active, b_burst, b_ls, b_fs, b_px, b_py}, q_b.pop_front());
   end

   task automatic run_a();
      repeat (5) @(posedge clk);
      @(negedge clk) rst_a_n = 1'b1;
      // Stop inside the normal horizontal sync of line 22, then reset asynchronously.
      repeat (22 * A_HT + 60) @(posedge clk);
      #2 rst_a_n = 1'b0;
      #1 compare("a_async_reset", {a_sync_n, a_active, a_burst, a_ls, a_fs, a_px, a_py}, RST_VEC);
      repeat (3) @(negedge clk);
      rst_a_n = 1'b1;
      repeat (300) @(posedge clk);
   endtask

   task automatic run_b();
      int ls_cnt, fs_cnt;
      repeat (7) @(posedge clk);
      @(negedge clk) rst_b_n = 1'b1;
      for (int f = 0; f < 2; f++) begin
         ls_cnt = 0;
         fs_cnt = 0;
         repeat (B_HT * B_VT) begin
            @(posedge clk);
            #1;
            if (b_ls) ls_cnt++;
            if (b_fs) fs_cnt++;
         end
         compare("b_line_starts_per_frame", 23'(ls_cnt), 23'(B_VT));
         compare("b_frame_starts_per_frame", 23'(fs_cnt), 23'd1);
      end
      // Random mid-frame asynchronous reset, then a further stretch of running.
      repeat ($urandom_range(B_HT * B_VT - 1, 1)) @(posedge clk);
      #3 rst_b_n = 1'b0;
      #1 compare("b_async_reset", {b_sync_n, b_active, b_burst, b_ls, b_fs, b_px, b_py}, RST_VEC);
      repeat ($urandom_range(4, 1)) @(negedge clk);
      rst_b_n = 1'b1;
      repeat (B_HT * B_VT + 500) @(posedge clk);
   endtask

   initial begin
      fork
         run_a();
         run_b();
      join
      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
